// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID output register, one-entry skid buffer and redirect drain.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
    parameter int                  WORD_LEN = 16,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hazard_detected_in,
    input  logic                brTaken,
    input  logic                jumpEnable,
    input  logic [WORD_LEN-1:0] redirect_target,
    output logic                imem_req,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [WORD_LEN-1:0] imem_rdata,
    output logic [WORD_LEN-1:0] instruction,
    output logic [WORD_LEN-1:0] pc_out,
    output logic                valid_out,
    output logic [15:0]         fetch_cnt,
    output logic [15:0]         stall_cnt
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [WORD_LEN-1:0] pc, pc_nxt;
    logic [WORD_LEN-1:0] pending, pending_nxt;
    logic [WORD_LEN-1:0] skid, skid_nxt;
    logic [WORD_LEN-1:0] skid_pc, skid_pc_nxt;
    logic [WORD_LEN-1:0] instr_nxt, pc_out_nxt;
    logic                valid_nxt;
    logic                redirect, consumed, can_load, load;

    assign redirect = brTaken | jumpEnable;
    assign consumed = ~hazard_detected_in;
    assign can_load = ~valid_out | consumed;

    // Request is gated by reset so nothing is issued during the reset cycle.
    assign imem_req  = rst && (state != HOLD);
    assign imem_addr = pc;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_nxt   = state;
        pc_nxt      = pc;
        pending_nxt = pending;
        skid_nxt    = skid;
        skid_pc_nxt = skid_pc;
        instr_nxt   = instruction;
        pc_out_nxt  = pc_out;
        load        = 1'b0;

        case (state)
            FETCH: begin
                if (redirect) begin
                    if (imem_ack) begin
                        pc_nxt = redirect_target;
                    end else begin
                        pending_nxt = redirect_target;
                        state_nxt   = DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_nxt = pc + 1'b1;
                    if (can_load) begin
                        load       = 1'b1;
                        instr_nxt  = imem_rdata;
                        pc_out_nxt = pc;
                    end else begin
                        skid_nxt    = imem_rdata;
                        skid_pc_nxt = pc;
                        state_nxt   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt    = redirect_target;
                    state_nxt = FETCH;
                end else if (consumed) begin
                    load       = 1'b1;
                    instr_nxt  = skid;
                    pc_out_nxt = skid_pc;
                    state_nxt  = FETCH;
                end
            end
            DRAIN: begin
                // The old request must complete before the new target is fetched.
                if (redirect) pending_nxt = redirect_target;
                if (imem_ack) begin
                    pc_nxt    = redirect ? redirect_target : pending;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase

        valid_nxt = valid_out & ~consumed;
        if (load)     valid_nxt = 1'b1;
        if (redirect) valid_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            valid_out   <= 1'b0;
            instruction <= '0;
            pc_out      <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            valid_out   <= valid_nxt;
            instruction <= instr_nxt;
            pc_out      <= pc_out_nxt;
        end
    end

    // NOTE: skid and pending are pure data qualified by state, so they carry no reset.
    always_ff @(posedge clk) begin
        pending <= pending_nxt;
        skid    <= skid_nxt;
        skid_pc <= skid_pc_nxt;
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (load)               fetch_cnt <= fetch_cnt + 1'b1;
            if (hazard_detected_in) stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign fetch_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage plus IF/ID pipeline register for the 16-bit pipeline. Holds the PC, issues requests to instruction memory over a req/ack handshake, and presents one instruction per cycle, with its PC and a valid flag, to the decode stage. Honours decode's hazard stall and applies branch/jump redirects, discarding wrong-path fetches. It sits directly upstream of the decode stage, whose `brTaken`, `jumpEnable` and `hazard_detected_in` drive it.

## Interface
- `WORD_LEN`, 16: instruction, PC and address width.
- `RESET_PC`, 16'h0000: PC loaded on reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `hazard_detected_in`  in  1  decode stall; the IF/ID output register must hold.
- `brTaken`  in  1  branch taken in decode this cycle.
- `jumpEnable`  in  1  jump in decode this cycle.
- `redirect_target`  in  WORD_LEN  new PC, valid when `brTaken|jumpEnable`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  WORD_LEN  fetch address; stable while `imem_req=1` and no ack.
- `imem_ack`  in  1  `imem_rdata` valid this cycle; request completes.
- `imem_rdata`  in  WORD_LEN  fetched instruction.
- `instruction`  out  WORD_LEN  IF/ID instruction to decode.
- `pc_out`  out  WORD_LEN  address of `instruction`.
- `valid_out`  out  1  `instruction` is a real instruction; 0 means bubble.
- `fetch_cnt`  out  16  instructions delivered (see Configuration).
- `stall_cnt`  out  16  cycles with `hazard_detected_in=1` (see Configuration).

## Operation
- `redirect = brTaken | jumpEnable`. Priority: reset > redirect > stall > advance.
- The output register is consumed on any cycle with `hazard_detected_in=0`. It can load when `valid_out=0` or it is consumed.
- FSM states: FETCH, HOLD, DRAIN.
- FETCH: `imem_req=1`, `imem_addr=pc`.
  - redirect & ack: discard data; `pc<=redirect_target`; stay.
  - redirect & no ack: `pending<=redirect_target`; go DRAIN.
  - ack & can load: `instruction<=imem_rdata`, `pc_out<=pc`, `valid_out<=1`, `pc<=pc+1`.
  - ack & cannot load: `skid<=imem_rdata`, `skid_pc<=pc`, `pc<=pc+1`; go HOLD.
  - no ack: hold `pc`; `imem_addr` unchanged.
- HOLD: `imem_req=0`.
  - redirect: drop skid; `pc<=redirect_target`; go FETCH.
  - no stall: output register loads skid and skid_pc; `valid_out<=1`; go FETCH.
- DRAIN: `imem_req=1`, `imem_addr` is the old `pc`.
  - further redirect: overwrites `pending`.
  - ack: discard data; `pc<=pending`; go FETCH.
- Flush: a redirect clears `valid_out` on the next edge regardless of `hazard_detected_in`. Otherwise, if consumed and nothing loads, `valid_out<=0`.
- PC arithmetic: word-addressed, `pc+1` modulo 2^WORD_LEN. 16'hFFFF wraps to 16'h0000 with no error.
- Reset values: state FETCH, `pc=RESET_PC`, `valid_out=0`, `instruction=0`, `pc_out=0`, counters 0, `imem_req=0` during the reset cycle.

## Timing
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle. `valid_out` first rises on the edge following the first cycle after reset release.
- Redirect penalty: a zero-wait redirect presents the target instruction 2 edges after the redirect cycle. DRAIN adds the remaining latency of the old request.
- `imem_ack` is ignored while `imem_req=0`.
- Reset during DRAIN or HOLD abandons the pending request and skid.
  - The memory must tolerate abandonment. The next request is to `RESET_PC`.
- Outputs are registered except `imem_req`/`imem_addr`, which decode from state and `pc`.

## Configuration
- `IF_PERF_CNT_EN` defined:
  - `fetch_cnt` increments on each `valid_out` load (wraps at 16 bits).
  - `stall_cnt` increments each cycle `hazard_detected_in=1` (wraps at 16 bits).
  - Both are cleared by reset.
- Not defined: counters are not built; `fetch_cnt` and `stall_cnt` are tied to 0.

## Test plan
- Zero-wait memory, `imem_rdata=16'hA000+addr`, no stalls, reset release → `pc_out` 0,1,2… on consecutive cycles; `instruction` 16'hA000,16'hA001…; `valid_out=1` from the 2nd edge on.
- Ack delayed 3 cycles → `imem_addr` stable for 3 cycles; one `valid_out` load per request; `pc` advances only on ack.
- Stall for 4 cycles with an instruction in flight → `instruction` held; skid captures the next fetch (HOLD, `imem_req=0`). On release, the skid instruction appears with the correct `pc_out`; none lost or duplicated.
- `brTaken=1`, `redirect_target=16'h0040`, zero-wait → next edge `valid_out=0`; following edge `pc_out=16'h0040`.
- Redirect to 16'h0080 while a 2-cycle-latency fetch of 16'h0005 is outstanding → DRAIN holds `imem_addr=16'h0005` until ack; data discarded; next request is 16'h0080.
- Start `pc=16'hFFFF` via redirect → next fetch 16'h0000. With `IF_PERF_CNT_EN`: 10 delivered, 3 stall cycles gives `fetch_cnt=10`, `stall_cnt=3`. Without the macro, both read 0.
